// File: rtl/root_tx_arbiter_pkg.sv
// Shared constants and types for the root transmit arbiter.
package root_tx_arbiter_pkg;

  localparam int unsigned ROOT_TX_REQ_RANK   = 0;
  localparam int unsigned ROOT_TX_REQ_ACT    = 1;
  localparam int unsigned ROOT_TX_FIFO_DEPTH = 2;

  typedef enum logic {
    REQ_RANK = 1'(ROOT_TX_REQ_RANK),
    REQ_ACT  = 1'(ROOT_TX_REQ_ACT)
  } root_tx_req_e;

endpackage

// File: rtl/root_tx_fifo.sv
// Small synchronous skid FIFO, one per requester; head data is read combinationally.
module root_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_push_data,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_head_data_c,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_rdy_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  // Ready depends on the count register only: a full FIFO refuses even while popping.
  assign o_rdy_c       = (r_count < CW'(DEPTH));
  assign w_push        = i_push && o_rdy_c;
  assign w_pop         = i_pop && (r_count != '0);
  assign o_head_data_c = r_mem[r_rd_ptr];
  assign o_count       = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/root_tx_arbiter.sv
// Shares the router LOCAL injection port between the rank and activation transmitters.
// Build option ROOT_TX_RANK_PRIO_EN selects fixed rank priority instead of round-robin.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module root_tx_arbiter
  import root_tx_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `ROUTER_WIDTH,
  parameter int unsigned FIFO_DEPTH = ROOT_TX_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rank_tx_en,
  input  logic [DATA_WIDTH-1:0] rank_tx_data,
  output logic                  rank_tx_rdy,
  input  logic                  act_tx_en,
  input  logic [DATA_WIDTH-1:0] act_tx_data,
  output logic                  act_tx_rdy,
  input  logic                  router_rdy,
  output logic                  out_tx_en,
  output logic [DATA_WIDTH-1:0] out_tx_data,
  output logic                  idle
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]         w_rank_count;
  logic [CW-1:0]         w_act_count;
  logic [DATA_WIDTH-1:0] w_rank_head;
  logic [DATA_WIDTH-1:0] w_act_head;
  logic                  w_rank_ne;
  logic                  w_act_ne;
  logic                  w_pop_valid;
  logic                  w_pop_rank;
  logic                  w_pop_act;
  root_tx_req_e          w_grant;

  root_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rank_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (rank_tx_en),
    .i_push_data   (rank_tx_data),
    .i_pop         (w_pop_rank),
    .o_head_data_c (w_rank_head),
    .o_count       (w_rank_count),
    .o_rdy_c       (rank_tx_rdy)
  );

  root_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_act_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (act_tx_en),
    .i_push_data   (act_tx_data),
    .i_pop         (w_pop_act),
    .o_head_data_c (w_act_head),
    .o_count       (w_act_count),
    .o_rdy_c       (act_tx_rdy)
  );

  assign w_rank_ne = (w_rank_count != '0);
  assign w_act_ne  = (w_act_count != '0);

`ifdef ROOT_TX_RANK_PRIO_EN
  always_comb begin
    w_grant = REQ_RANK;
    if (!w_rank_ne) w_grant = REQ_ACT;
  end
`else
  root_tx_req_e r_last_grant;

  // On a tie, serve whoever did not win last; last_grant only moves on a pop.
  always_comb begin
    w_grant = REQ_RANK;
    if (w_rank_ne && w_act_ne) begin
      w_grant = (r_last_grant == REQ_ACT) ? REQ_RANK : REQ_ACT;
    end else if (!w_rank_ne) begin
      w_grant = REQ_ACT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= REQ_ACT;
    end else if (w_pop_valid) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  assign w_pop_valid = router_rdy && (w_rank_ne || w_act_ne);
  assign w_pop_rank  = w_pop_valid && (w_grant == REQ_RANK);
  assign w_pop_act   = w_pop_valid && (w_grant == REQ_ACT);

  // Output register: data holds its last value when no flit is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tx_en   <= 1'b0;
      out_tx_data <= '0;
    end else begin
      out_tx_en <= w_pop_valid;
      if (w_pop_valid) begin
        out_tx_data <= (w_grant == REQ_RANK) ? w_rank_head : w_act_head;
      end
    end
  end

  assign idle = !out_tx_en && !w_rank_ne && !w_act_ne;

endmodule
